// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the EX stage (port 0)
// and the branch-compare/address unit (port 1), with a one-deep response buffer per port.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_opdA,
  input  logic [DATA_W-1:0] req0_opdB,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_opdA,
  input  logic [DATA_W-1:0] req1_opdB,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [DATA_W-1:0] alu_opdA,
  output logic [DATA_W-1:0] alu_opdB,
  output logic [OP_W-1:0]   alu_op_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [DATA_W-1:0]   iss_opda_r, iss_opdb_r;
  logic [OP_W-1:0]     iss_op_r;
  logic                owner_r;
  logic                last_grant_r;
  logic                rsp0_valid_r, rsp1_valid_r;
  logic [DATA_W-1:0]   rsp0_data_r, rsp1_data_r;
  logic                elig0_s, elig1_s;
  logic                gnt_vld_s, gnt_id_s;

  // A port holding an undrained result is not eligible until it is consumed.
  assign elig0_s = req0_valid & ~rsp0_valid_r;
  assign elig1_s = req1_valid & ~rsp1_valid_r;

  // Round-robin grant, only offered in IDLE and never while reset is asserted
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      if (elig0_s && elig1_s) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = ~last_grant_r;
      end else if (elig0_s) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b0;
      end else if (elig1_s) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b1;
      end else begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
      end
    end else begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  assign req0_ready = gnt_vld_s & ~gnt_id_s;
  assign req1_ready = gnt_vld_s & gnt_id_s;

  // Next-state logic: a grant is always an accept since eligibility implies valid
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = gnt_vld_s ? EXEC : IDLE;
      EXEC:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Issue registers and round-robin pointer, loaded on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_opda_r   <= {DATA_W{1'b0}};
      iss_opdb_r   <= {DATA_W{1'b0}};
      iss_op_r     <= {OP_W{1'b0}};
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (gnt_vld_s) begin
      iss_opda_r   <= gnt_id_s ? req1_opdA : req0_opdA;
      iss_opdb_r   <= gnt_id_s ? req1_opdB : req0_opdB;
      iss_op_r     <= gnt_id_s ? req1_op   : req0_op;
      owner_r      <= gnt_id_s;
      last_grant_r <= gnt_id_s;
    end
  end

  // Response buffers: capture ALU result at end of EXEC, clear on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_data_r  <= {DATA_W{1'b0}};
      rsp1_data_r  <= {DATA_W{1'b0}};
    end else begin
      if ((state_r == EXEC) && !owner_r) begin
        rsp0_valid_r <= 1'b1;
        rsp0_data_r  <= alu_out;
      end else if (rsp0_valid_r && rsp0_ready) begin
        rsp0_valid_r <= 1'b0;
      end
      if ((state_r == EXEC) && owner_r) begin
        rsp1_valid_r <= 1'b1;
        rsp1_data_r  <= alu_out;
      end else if (rsp1_valid_r && rsp1_ready) begin
        rsp1_valid_r <= 1'b0;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_data  = rsp0_data_r;
  assign rsp1_data  = rsp1_data_r;
  assign alu_opdA   = iss_opda_r;
  assign alu_opdB   = iss_opdb_r;
  assign alu_op_sel = iss_op_r;
  assign busy       = (state_r == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, directed scenarios
// followed by random traffic, all compared against a transaction-level model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_opdA, req0_opdB, req1_opdA, req1_opdB;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [DW-1:0] alu_opdA, alu_opdB, alu_out;
  logic [OW-1:0] alu_op_sel;
  logic          busy;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opdA(req0_opdA),
    .req0_opdB(req0_opdB), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opdA(req1_opdA),
    .req1_opdB(req1_opdB), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_opdA(alu_opdA), .alu_opdB(alu_opdB), .alu_op_sel(alu_op_sel),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4,
                         SRL = 4'd5, SRA = 4'd6, SLL = 4'd7, SLT = 4'd8, SLTU = 4'd9;

  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      XOR:     return a ^ b;
      OR:      return a | b;
      AND:     return a & b;
      SRL:     return a >> b[4:0];
      SRA:     return $unsigned($signed(a) >>> b[4:0]);
      SLL:     return a << b[4:0];
      SLT:     return {31'd0, $signed(a) < $signed(b)};
      SLTU:    return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_opdA, alu_opdB, alu_op_sel);

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: one op in flight, one buffered result per port.
  bit            m_busy, m_owner, m_last;
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] m_res, m_ia, m_ib;
  logic [OW-1:0] m_iop;

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    m_res = '0; m_ia = '0; m_ib = '0; m_iop = '0;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(output int g);
    bit e0, e1;
    e0 = !m_busy && !rst && req0_valid && !m_rv[0];
    e1 = !m_busy && !rst && req1_valid && !m_rv[1];
    if (e0 && e1) g = m_last ? 0 : 1;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    chk("busy",       {31'd0, busy},       {31'd0, m_busy});
    chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_rv[0]});
    chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_rv[1]});
    chk("rsp0_data",  rsp0_data, m_rd[0]);
    chk("rsp1_data",  rsp1_data, m_rd[1]);
    chk("alu_opdA",   alu_opdA,  m_ia);
    chk("alu_opdB",   alu_opdB,  m_ib);
    chk("alu_op_sel", {28'd0, alu_op_sel}, {28'd0, m_iop});
  endtask

  // One clock: drive, check just after inputs settle, advance model, step past the edge.
  task automatic cycle(input bit v0, input logic [3:0] op0, input logic [DW-1:0] a0,
                       input logic [DW-1:0] b0, input bit v1, input logic [3:0] op1,
                       input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input bit rr0, input bit rr1);
    int g;
    req0_valid = v0; req0_op = op0; req0_opdA = a0; req0_opdB = b0;
    req1_valid = v1; req1_op = op1; req1_opdA = a1; req1_opdB = b1;
    rsp0_ready = rr0; rsp1_ready = rr1;
    #1;
    check_all(g);
    if (m_rv[0] && rr0) m_rv[0] = 1'b0;
    if (m_rv[1] && rr1) m_rv[1] = 1'b0;
    if (m_busy) begin
      m_rv[m_owner] = 1'b1;
      m_rd[m_owner] = m_res;
      m_busy = 1'b0;
    end else if (g >= 0) begin
      m_busy  = 1'b1;
      m_owner = (g == 1);
      m_last  = (g == 1);
      m_ia    = (g == 1) ? a1  : a0;
      m_ib    = (g == 1) ? b1  : b0;
      m_iop   = (g == 1) ? op1 : op0;
      m_res   = alu_ref(m_ia, m_ib, m_iop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr0, input bit rr1);
    for (int i = 0; i < n; i++) cycle(1'b0, ADD, '0, '0, 1'b0, ADD, '0, '0, rr0, rr1);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_op = ADD; req1_op = ADD;
    req0_opdA = 32'd1; req0_opdB = 32'd1; req1_opdA = 32'd1; req1_opdB = 32'd1;
    model_reset();
    #12;
    begin
      int g;
      check_all(g);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op on port 0: ADD 5+7
    cycle(1'b1, ADD, 32'd5, 32'd7, 1'b0, ADD, '0, '0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    chk("single_add_data", rsp0_data, 32'd12);
    idle(1, 1'b1, 1'b0);

    // Contention with immediate drain: expect grants 0,1,0,1
    for (int i = 0; i < 9; i++)
      cycle(1'b1, SUB, 32'd10, 32'd3, 1'b1, SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    chk("contend_rsp0", rsp0_data, 32'd7);
    chk("contend_rsp1", rsp1_data, 32'd1);
    idle(2, 1'b1, 1'b1);

    // Backpressure on port 1 while port 0 keeps being served
    cycle(1'b0, ADD, '0, '0, 1'b1, SRA, 32'h8000_0000, 32'd4, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    chk("bp_sra_data", rsp1_data, 32'hF800_0000);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, OR, i, 32'h100, 1'b1, AND, 32'hFF, 32'h0F, 1'b1, 1'b0);
    chk("bp_sra_held", rsp1_data, 32'hF800_0000);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, OR, 32'd3, 32'h100, 1'b1, AND, 32'hFF, 32'h0F, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Fairness: port 1 alone three times, then contention
    for (int i = 0; i < 6; i++)
      cycle(1'b0, ADD, '0, '0, 1'b1, ADD, i, 32'd100, 1'b1, 1'b1);
    idle(1, 1'b1, 1'b1);
    cycle(1'b1, SLTU, 32'd1, 32'd2, 1'b1, SLL, 32'd3, 32'd2, 1'b1, 1'b1);
    chk("fair_last_grant_port0", alu_op_sel, SLTU);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, SLTU, 32'd1, 32'd2, 1'b1, SLL, 32'd3, 32'd2, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Reset during EXEC of port 0 XOR
    cycle(1'b1, XOR, 32'hFF, 32'h0F, 1'b0, ADD, '0, '0, 1'b1, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_rdy0",   {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1",   {31'd0, req1_ready}, 32'd0);
    chk("rst_alu_a",  alu_opdA,            32'd0);
    chk("rst_alu_op", {28'd0, alu_op_sel}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    rst = 1'b0;
    idle(2, 1'b1, 1'b1);
    cycle(1'b1, XOR, 32'hFF, 32'h0F, 1'b0, ADD, '0, '0, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);
    chk("post_rst_xor", rsp0_data, 32'hF0);
    idle(1, 1'b1, 1'b1);

    // Shift amount masking: only opdB[4:0] matters
    cycle(1'b1, SLL, 32'd1, 32'h21, 1'b0, ADD, '0, '0, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);
    chk("sll_mask", rsp0_data, 32'd2);
    chk("sll_opdB_passthru", alu_opdB, 32'h21);
    idle(1, 1'b1, 1'b1);

    // Random traffic, including undefined op codes
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
